baby_vga_scan_gen: RTL and testbench

Scan-timing generator for the baby VGA peripheral, sitting directly upstream of the pixel/framebuffer output stage. It runs 640x480@60-style raster timing straight off the 64 MHz system clock. It drives the 32x16 framebuffer cell coordinates (`x_pos`, `y_pos`), the sync pulses, a blanking flag and a sticky interrupt for the TinyQV core. Line length is 2034 system clocks, and each framebuffer cell is CELL_W clocks wide and CELL_H lines tall.

---
 rtl/baby_vga_scan_gen.sv | 168 ++++++++++++++++
 tb/tb_baby_vga_scan_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/baby_vga_scan_gen.sv
// baby_vga_scan_gen: raster scan-timing generator for the baby VGA peripheral.
// Produces 32x16 framebuffer cell coordinates, active-low sync pulses, a
// blanking flag, a frame-start strobe and a sticky interrupt request.
// Optional build macro: BABY_VGA_ROW_IRQ_EN (adds a per-row interrupt set event).
module baby_vga_scan_gen #(
  parameter int unsigned CELL_W  = 50,
  parameter int unsigned CELL_H  = 30,
  parameter int unsigned H_FRONT = 41,
  parameter int unsigned H_SYNC  = 244,
  parameter int unsigned H_BACK  = 149,
  parameter int unsigned V_FRONT = 10,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BACK  = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cli,
  output logic [4:0] x_pos,
  output logic [3:0] y_pos,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic       frame_start,
  output logic       interrupt
);

  localparam int unsigned H_ACTIVE = 32 * CELL_W;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_ACTIVE = 16 * CELL_H;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_ACT_C    = 11'(H_ACTIVE);
  localparam logic [10:0] H_LAST_C   = 11'(H_TOTAL - 1);
  localparam logic [10:0] HS_START_C = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] HS_END_C   = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0]  V_ACT_C    = 10'(V_ACTIVE);
  localparam logic [9:0]  V_LAST_C   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VS_START_C = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0]  VS_END_C   = 10'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [5:0]  COL_LAST_C = 6'(CELL_W - 1);
  localparam logic [4:0]  ROW_LAST_C = 5'(CELL_H - 1);

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [5:0]  col_sub_q, col_sub_d;
  logic [4:0]  row_sub_q, row_sub_d;
  logic [4:0]  x_pos_q, x_pos_d;
  logic [3:0]  y_pos_q, y_pos_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        blank_q, blank_d;
  logic        frame_start_q, frame_start_d;
  logic        irq_q, irq_d;
  logic        run_q, run_d;
  logic        line_end, frame_end;
  logic        vblank_set, irq_set;

  // Counter advance. The first edge after reset parks the raster at (0,0)
  // rather than advancing, so that cycle carries the frame-start strobe.
  always_comb begin
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    col_sub_d = col_sub_q;
    row_sub_d = row_sub_q;
    x_pos_d   = x_pos_q;
    y_pos_d   = y_pos_q;
    run_d     = 1'b1;
    line_end  = (h_cnt_q == H_LAST_C);
    frame_end = line_end && (v_cnt_q == V_LAST_C);
    if (!run_q) begin
      h_cnt_d   = '0;
      v_cnt_d   = '0;
      col_sub_d = '0;
      row_sub_d = '0;
      x_pos_d   = '0;
      y_pos_d   = '0;
    end else begin
      h_cnt_d = line_end ? '0 : h_cnt_q + 11'd1;
      if (line_end) begin
        v_cnt_d = frame_end ? '0 : v_cnt_q + 10'd1;
      end
      if (line_end) begin
        col_sub_d = '0;
        x_pos_d   = '0;
      end else if (h_cnt_d < H_ACT_C) begin
        if (col_sub_q == COL_LAST_C) begin
          col_sub_d = '0;
          if (x_pos_q != 5'd31) x_pos_d = x_pos_q + 5'd1;
        end else begin
          col_sub_d = col_sub_q + 6'd1;
        end
      end
      if (frame_end) begin
        row_sub_d = '0;
        y_pos_d   = '0;
      end else if (line_end && (v_cnt_d < V_ACT_C)) begin
        if (row_sub_q == ROW_LAST_C) begin
          row_sub_d = '0;
          if (y_pos_q != 4'd15) y_pos_d = y_pos_q + 4'd1;
        end else begin
          row_sub_d = row_sub_q + 5'd1;
        end
      end
    end
  end

  // Interrupt set events: entry into vertical blanking, plus optional row wraps.
  always_comb begin
    vblank_set = run_q && line_end && (v_cnt_d == V_ACT_C);
`ifdef BABY_VGA_ROW_IRQ_EN
    irq_set = vblank_set ||
              (run_q && line_end && !frame_end && (v_cnt_d < V_ACT_C) &&
               (row_sub_q == ROW_LAST_C));
`else
    irq_set = vblank_set;
`endif
  end

  // Output decode from next-state counters, so registered outputs line up
  // with the counter values held in the same cycle.
  always_comb begin
    hsync_d       = !((h_cnt_d >= HS_START_C) && (h_cnt_d < HS_END_C));
    vsync_d       = !((v_cnt_d >= VS_START_C) && (v_cnt_d < VS_END_C));
    blank_d       = (h_cnt_d >= H_ACT_C) || (v_cnt_d >= V_ACT_C);
    frame_start_d = (h_cnt_d == '0) && (v_cnt_d == '0);
    irq_d         = irq_set || (irq_q && !cli);
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      col_sub_q     <= '0;
      row_sub_q     <= '0;
      x_pos_q       <= '0;
      y_pos_q       <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_q       <= 1'b0;
      frame_start_q <= 1'b0;
      irq_q         <= 1'b0;
      run_q         <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      col_sub_q     <= col_sub_d;
      row_sub_q     <= row_sub_d;
      x_pos_q       <= x_pos_d;
      y_pos_q       <= y_pos_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
      irq_q         <= irq_d;
      run_q         <= run_d;
    end
  end

  assign x_pos       = x_pos_q;
  assign y_pos       = y_pos_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank       = blank_q;
  assign frame_start = frame_start_q;
  assign interrupt   = irq_q;

endmodule

// File: tb/tb_baby_vga_scan_gen.sv
// Self-checking bench for baby_vga_scan_gen using a shrunk raster geometry:
// 96+2+3+4 = 105 clocks per line, 32+1+2+2 = 37 lines per frame.
module tb_baby_vga_scan_gen;

  localparam int CW    = 3;
  localparam int CH    = 2;
  localparam int HF    = 2;
  localparam int HS    = 3;
  localparam int HB    = 4;
  localparam int VF    = 1;
  localparam int VS    = 2;
  localparam int VB    = 2;
  localparam int HA    = 32 * CW;
  localparam int HT    = HA + HF + HS + HB;
  localparam int VA    = 16 * CH;
  localparam int VT    = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst;
  logic       cli;
  logic [4:0] x_pos;
  logic [3:0] y_pos;
  logic       hsync, vsync, blank, frame_start, interrupt;

  baby_vga_scan_gen #(
    .CELL_W (CW),
    .CELL_H (CH),
    .H_FRONT(HF),
    .H_SYNC (HS),
    .H_BACK (HB),
    .V_FRONT(VF),
    .V_SYNC (VS),
    .V_BACK (VB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cli        (cli),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .hsync      (hsync),
    .vsync      (vsync),
    .blank      (blank),
    .frame_start(frame_start),
    .interrupt  (interrupt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic [4:0] x;
    logic [3:0] y;
    logic       hs, vs, bl, fs, irq;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;
  int   n_abs = -1;   // cycles since last reset release
  int   mt    = -1;   // model position within frame, -1 while in reset
  logic m_irq = 1'b0;

  function automatic logic [13:0] got_vec();
    return {x_pos, y_pos, hsync, vsync, blank, frame_start, interrupt};
  endfunction

  // Reference outputs from raster position arithmetic.
  function automatic logic [13:0] model_out();
    int h, v;
    logic [4:0] x;
    logic [3:0] y;
    logic hs_v, vs_v, bl_v, fs_v;
    if (mt < 0) return {5'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, m_irq};
    h    = mt % HT;
    v    = mt / HT;
    x    = (h < HA) ? 5'(h / CW) : 5'd31;
    y    = (v < VA) ? 4'(v / CH) : 4'd15;
    hs_v = !(h >= HA + HF && h < HA + HF + HS);
    vs_v = !(v >= VA + VF && v < VA + VF + VS);
    bl_v = (h >= HA) || (v >= VA);
    fs_v = (mt == 0);
    return {x, y, hs_v, vs_v, bl_v, fs_v, m_irq};
  endfunction

  task automatic model_edge(input logic r, input logic c);
    int  h, v;
    logic set;
    if (r) begin
      mt    = -1;
      m_irq = 1'b0;
    end else begin
      mt  = (mt < 0) ? 0 : (mt + 1) % FRAME;
      h   = mt % HT;
      v   = mt / HT;
      set = (h == 0) && (v == VA);
`ifdef BABY_VGA_ROW_IRQ_EN
      if (h == 0 && v > 0 && v < VA && (v % CH) == 0) set = 1'b1;
`endif
      m_irq = set || (m_irq && !c);
    end
  endtask

  task automatic cmp(input string name, input logic [13:0] want, input logic [13:0] mask);
    logic [13:0] got;
    got = got_vec();
    tests++;
    if ((got & mask) !== (want & mask)) begin
      fails++;
      $display("FAIL %s n=%0d got{x,y,hs,vs,bl,fs,irq}=%b want=%b mask=%b",
               name, n_abs, got, want, mask);
    end
  endtask

  // One clock: c is cli during the current cycle, r is rst at the coming edge.
  task automatic tick(input logic r, input logic c);
    rst = r;
    cli = c;
    @(posedge clk);
    model_edge(r, c);
    n_abs = r ? -1 : n_abs + 1;
    #1;
    cmp("model", model_out(), '1);
  endtask

  function automatic logic cli_sched(input int n);
    return (n == 3440) || (n == 7243) || (n == 7244);
  endfunction

  task automatic add(input int n, input int x, input int y, input logic hs,
                     input logic vs, input logic bl, input logic fs, input logic irq);
    vec_t e;
    e.n = n; e.x = 5'(x); e.y = 4'(y);
    e.hs = hs; e.vs = vs; e.bl = bl; e.fs = fs; e.irq = irq;
    vecs.push_back(e);
  endtask

  initial begin
    logic [13:0] tmask;
    logic        reached;
`ifdef BABY_VGA_ROW_IRQ_EN
    tmask = 14'h3FFE;
`else
    tmask = 14'h3FFF;
`endif
    //   n     x   y  hs vs bl fs irq
    add(0,     0,  0, 1, 1, 0, 1, 0);
    add(1,     0,  0, 1, 1, 0, 0, 0);
    add(2,     0,  0, 1, 1, 0, 0, 0);
    add(3,     1,  0, 1, 1, 0, 0, 0);
    add(93,   31,  0, 1, 1, 0, 0, 0);
    add(95,   31,  0, 1, 1, 0, 0, 0);
    add(96,   31,  0, 1, 1, 1, 0, 0);
    add(97,   31,  0, 1, 1, 1, 0, 0);
    add(98,   31,  0, 0, 1, 1, 0, 0);
    add(100,  31,  0, 0, 1, 1, 0, 0);
    add(101,  31,  0, 1, 1, 1, 0, 0);
    add(104,  31,  0, 1, 1, 1, 0, 0);
    add(105,   0,  0, 1, 1, 0, 0, 0);
    add(210,   0,  1, 1, 1, 0, 0, 0);
    add(3150,  0, 15, 1, 1, 0, 0, 0);
    add(3350, 31, 15, 1, 1, 0, 0, 0);
    add(3359, 31, 15, 1, 1, 1, 0, 0);
    add(3360,  0, 15, 1, 1, 1, 0, 1);
    add(3440, 26, 15, 1, 1, 1, 0, 1);
    add(3441, 27, 15, 1, 1, 1, 0, 0);
    add(3465,  0, 15, 1, 0, 1, 0, 0);
    add(3674, 31, 15, 1, 0, 1, 0, 0);
    add(3675,  0, 15, 1, 1, 1, 0, 0);
    add(3884, 31, 15, 1, 1, 1, 0, 0);
    add(3885,  0,  0, 1, 1, 0, 1, 0);
    add(7244, 31, 15, 1, 1, 1, 0, 0);
    add(7245,  0, 15, 1, 1, 1, 0, 1);
    add(7246,  0, 15, 1, 1, 1, 0, 1);

    rst = 1'b1;
    cli = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0);
      cmp("reset", {5'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}, '1);
    end

    // Directed raster points, with a cli pulse and a cli/set collision.
    for (int i = 0; i < vecs.size(); i++) begin
      while (n_abs < vecs[i].n) tick(1'b0, cli_sched(n_abs));
      cmp("vec", {vecs[i].x, vecs[i].y, vecs[i].hs, vecs[i].vs, vecs[i].bl,
                  vecs[i].fs, vecs[i].irq}, tmask);
    end

    // Random sparse cli over more than a full frame.
    repeat (FRAME + 200) tick(1'b0, ($urandom_range(0, 63) == 0));

    // Run quietly to the vertical-blank set point, then reset mid-frame.
    reached = 1'b0;
    for (int k = 0; k < 2 * FRAME && !reached; k++) begin
      tick(1'b0, 1'b0);
      reached = (mt == VA * HT);
    end
    tests++;
    if (!reached) begin
      fails++;
      $display("FAIL reach_vblank got=0 want=1");
    end
    repeat (HT + 5) tick(1'b0, 1'b0);
    cmp("irq_pre_rst", {x_pos, y_pos, hsync, vsync, blank, frame_start, 1'b1}, 14'h0001);
    tick(1'b1, 1'b0);
    cmp("rst_mid", {5'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}, '1);
    tick(1'b0, 1'b0);
    cmp("restart", {5'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}, '1);
    repeat (300) tick(1'b0, ($urandom_range(0, 15) == 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
